idct8_da_row: RTL and testbench
===============================

// Module: idct8_da_row
// PURPOSE
// - 8-point 1-D inverse DCT using bit-serial distributed arithmetic (DA). Decode-side counterpart of the forward-DCT DA row engine.
// - Accepts one 8-coefficient row X[0..7] and returns 8 reconstructed EEG samples x[0..7].
// - Sits between the RLE decoder output and the sample reassembly buffer in the decompression path.
// - Even/odd split: E[n] from X0,X2,X4,X6 and O[n] from X1,X3,X5,X7 (n=0..3), then x[n]=E[n]+O[n] and x[7-n]=E[n]-O[n].
// PARAMETERS
// - DW    16  signed width of input coefficients and output samples (two's complement).
// - ROMW  17  signed width of DA table entries, Q2.15.
// - ACCW  DW+ROMW+3  accumulator width.
// PORTS
// - clk        in   1   clock; all logic on posedge.
// - rst        in   1   synchronous, active-high reset.
// - in_valid   in   1   coefficient on in_data is valid.
// - in_ready   out  1   block can accept a coefficient.
// - in_data    in   DW  coefficient, strictly in order X0..X7.
// - out_valid  out  1   out_data holds a valid sample.
// - out_ready  in   1   downstream accepts the sample.
// - out_data   out  DW  reconstructed sample, order x0..x7.
// - out_last   out  1   high with x7.
// BEHAVIOUR
// - Reset: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, all counters and accumulators cleared. Any partial row is discarded.
// - FSM LOAD:
//   - A coefficient is taken on each in_valid&&in_ready cycle into reg X[idx]; idx counts 0..7.
//   - After X7 is taken: in_ready=0, go to CALC with bit=DW-1.
// - FSM CALC: runs for DW cycles, one bit plane per cycle, MSB first.
//   - Even address ae = {X6[b],X4[b],X2[b],X0[b]}; odd address ao = {X7[b],X5[b],X3[b],X1[b]}.
//   - 8 internal 16-entry tables:
//     - TE_n[a] = 0.5*sum_i a_i*Ck*cos((2n+1)k*pi/16), k = 2i.
//     - TO_n[a] = the same with k = 2i+1.
//     - C0 = 1/sqrt(2); otherwise Ck = 1.
//     - Entries are rounded to Q2.15.
//   - Accumulator update per output n:
//     - b = DW-1 (sign bit): accE_n = -TE_n[ae], accO_n = -TO_n[ao].
//     - Other bits: acc = (acc<<<1) + table.
//   - After bit 0: form s_n = (acc + 2^14) >>> 15 for all 8 accumulators (round half up), combine E±O, go to OUT.
// - FSM OUT:
//   - out_valid=1; out_data presents x[oidx], oidx 0..7.
//   - oidx advances only on out_valid&&out_ready; out_data/out_valid must stay stable while out_ready=0.
//   - On the x7 handshake: out_valid=0, return to LOAD, in_ready=1 on the next cycle.
// - Latency: last input handshake to first out_valid = DW+1 cycles (16 CALC cycles + 1 combine cycle).
// - Throughput: one row per 8+DW+1+8 cycles with no stalls. Input and output phases do not overlap.
// - Boundaries:
//   - in_valid during CALC or OUT is ignored (in_ready=0), with no side effects.
//   - in_valid gaps during LOAD stall idx.
//   - rst in any state wins over every other event and aborts the row.
//   - Accumulators are sized so no internal overflow occurs for any DW-bit input.
// - Arithmetic: all adds are signed ACCW-bit. E±O is computed at DW+2 bits, then reduced to DW bits as set under CONFIGURATION.
// CONFIGURATION
// - Macro IDCT_SAT_EN.
//   - Defined: each x[n] is clamped to [-2^(DW-1), 2^(DW-1)-1].
//   - Undefined: each x[n] is truncated to its low DW bits (two's-complement wrap).
// TESTING
// - T1 zeros: X=all 0 -> x0..x7 = 0; out_last only with x7; latency = DW+1.
// - T2 DC: X0=1024, rest 0 -> all x = 362 (±1).
// - T3 X1=1000, rest 0 -> x = 490, 416, 278, 98, -98, -278, -416, -490 (±1).
// - T4 saturation: X0=X2=X4=X6=32767, odd=0.
//   - x0 is about 44600.
//   - IDCT_SAT_EN defined: x0 = 32767.
//   - IDCT_SAT_EN undefined: x0 = low 16 bits of the value (negative).
// - T5 backpressure: random out_ready low and random in_valid gaps -> output matches the golden model; out_data is stable while stalled.
// - T6 reset mid-CALC: assert rst at bit 8 -> next cycle in_ready=1, out_valid=0; the next row decodes correctly with no remnants.

Source files
------------

// File: rtl/idct8_da_row_if.sv
// Stream interface for the 8-point DA inverse-DCT row engine.
// The coefficient input and the sample output are both valid/ready streams.
interface idct8_da_row_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/idct8_da_row.sv
// 8-point 1-D inverse DCT, bit-serial distributed arithmetic with even/odd split.
// Optional macro IDCT_SAT_EN clamps outputs to DW bits; otherwise results wrap.
module idct8_da_row #(
  parameter int DW   = 16,
  parameter int ROMW = 17,
  parameter int ACCW = DW + ROMW + 3
) (
  input  logic               clk,
  input  logic               rst,
  idct8_da_row_if.slave      io
);
  localparam int BW = $clog2(DW);

  // Q2.15 weights 0.5*Ck*cos((2n+1)k*pi/16); a DA table entry is the sum of selected weights.
  localparam int CE [4][4] = '{
    '{11585,  15137,  11585,   6270},
    '{11585,   6270, -11585, -15137},
    '{11585,  -6270, -11585,  15137},
    '{11585, -15137,  11585,  -6270}
  };
  localparam int CO [4][4] = '{
    '{16069,  13623,   9102,   3196},
    '{13623,  -3196, -16069,  -9102},
    '{ 9102, -16069,   3196,  13623},
    '{ 3196,  -9102,  13623, -16069}
  };

  localparam logic signed [ACCW-1:0] RND  = ACCW'(32'sd16384);
  localparam logic signed [DW+1:0]   SMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0]   SMIN = {3'b111, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, CALC, COMB, OUT} state_t;

  function automatic logic signed [ACCW-1:0] tab_e(input int n, input logic [3:0] a);
    logic signed [ACCW-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) if (a[i]) s = s + ACCW'(CE[n][i]);
    return s;
  endfunction

  function automatic logic signed [ACCW-1:0] tab_o(input int n, input logic [3:0] a);
    logic signed [ACCW-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) if (a[i]) s = s + ACCW'(CO[n][i]);
    return s;
  endfunction

  function automatic logic signed [DW+1:0] rnd15(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] t;
    t = (a + RND) >>> 15;
    return t[DW+1:0];
  endfunction

  function automatic logic [DW-1:0] reduce(input logic signed [DW+1:0] v);
`ifdef IDCT_SAT_EN
    if (v > SMAX)      return SMAX[DW-1:0];
    else if (v < SMIN) return SMIN[DW-1:0];
    else               return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d, oidx_q, oidx_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DW-1:0]          x_q [8], x_d [8];
  logic [DW-1:0]          xo_q [8], xo_d [8];
  logic signed [ACCW-1:0] acc_e_q [4], acc_e_d [4], acc_o_q [4], acc_o_d [4];
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]          out_data_q, out_data_d;

  always_comb begin
    logic [3:0]             ae, ao;
    logic signed [ACCW-1:0] te, to;
    logic signed [DW+1:0]   se, so;
    state_d     = state_q;
    idx_d       = idx_q;
    oidx_d      = oidx_q;
    bit_d       = bit_q;
    x_d         = x_q;
    xo_d        = xo_q;
    acc_e_d     = acc_e_q;
    acc_o_d     = acc_o_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    ae = {x_q[6][bit_q], x_q[4][bit_q], x_q[2][bit_q], x_q[0][bit_q]};
    ao = {x_q[7][bit_q], x_q[5][bit_q], x_q[3][bit_q], x_q[1][bit_q]};
    te = '0;
    to = '0;
    se = '0;
    so = '0;
    case (state_q)
      LOAD: if (io.in_valid && in_ready_q) begin
        x_d[idx_q] = io.in_data;
        idx_d      = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          in_ready_d = 1'b0;
          bit_d      = BW'(DW - 1);
          state_d    = CALC;
        end
      end
      CALC: begin
        // The sign bit plane carries weight -2^(DW-1), so it seeds the accumulator negated.
        for (int n = 0; n < 4; n++) begin
          te = tab_e(n, ae);
          to = tab_o(n, ao);
          if (bit_q == BW'(DW - 1)) begin
            acc_e_d[n] = -te;
            acc_o_d[n] = -to;
          end else begin
            acc_e_d[n] = (acc_e_q[n] <<< 1) + te;
            acc_o_d[n] = (acc_o_q[n] <<< 1) + to;
          end
        end
        bit_d = bit_q - 1'b1;
        if (bit_q == '0) state_d = COMB;
      end
      COMB: begin
        for (int n = 0; n < 4; n++) begin
          se          = rnd15(acc_e_q[n]);
          so          = rnd15(acc_o_q[n]);
          xo_d[n]     = reduce(se + so);
          xo_d[7 - n] = reduce(se - so);
        end
        out_data_d  = xo_d[0];
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        oidx_d      = 3'd0;
        state_d     = OUT;
      end
      OUT: if (out_valid_q && io.out_ready) begin
        if (oidx_q == 3'd7) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_data_d  = '0;
          in_ready_d  = 1'b1;
          idx_d       = 3'd0;
          state_d     = LOAD;
        end else begin
          oidx_d     = oidx_q + 3'd1;
          out_data_d = xo_q[oidx_q + 3'd1];
          out_last_d = (oidx_q == 3'd6);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      oidx_q      <= '0;
      bit_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        x_q[i]  <= '0;
        xo_q[i] <= '0;
      end
      for (int n = 0; n < 4; n++) begin
        acc_e_q[n] <= '0;
        acc_o_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      bit_q       <= bit_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      x_q         <= x_d;
      xo_q        <= xo_d;
      acc_e_q     <= acc_e_d;
      acc_o_q     <= acc_o_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_last  = out_last_q;
endmodule

// File: tb/tb_idct8_da_row.sv
// Directed bench for idct8_da_row: fixed rows with hand-derived samples,
// back-pressure rows against a real-valued IDCT, mid-row reset.
module tb_idct8_da_row;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   t0 = 0;

  idct8_da_row_if #(.DW(DW)) io ();

  idct8_da_row #(.DW(DW)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    n_chk++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic int model(input int xs[8], input int n);
    real s, ck;
    s = 0.0;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      s  = s + 0.5 * ck * real'(xs[k]) * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    end
    return int'(s);
  endfunction

  task automatic send_row(input int xs[8], input int gap);
    int wd;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(99) < gap) begin
        io.in_valid = 1'b0;
        io.in_data  = 16'($urandom);
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      io.in_valid = 1'b1;
      io.in_data  = 16'(xs[i]);
      wd = 0;
      while (!io.in_ready && wd < 60) begin
        @(posedge clk); #1;
        wd++;
      end
      if (!io.in_ready) begin
        chk("in_ready_timeout", 0, 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic recv_row(output int got[8], input int stall, input string tag);
    int  wd, d, lat;
    bit  to;
    to = 1'b0;
    for (int i = 0; i < 8; i++) got[i] = 0;
    wd = 0;
    while (!io.out_valid && wd < 100) begin
      @(posedge clk); #1;
      wd++;
    end
    lat = cyc - t0;
    chk({tag, "_latency"}, lat, DW + 1, 0);
    for (int i = 0; i < 8 && !to; i++) begin
      io.out_ready = ($urandom_range(99) >= stall);
      wd = 0;
      while (!(io.out_valid && io.out_ready)) begin
        if (wd > 60) begin
          chk({tag, "_out_timeout"}, 0, 1, 0);
          to = 1'b1;
          break;
        end
        if (io.out_valid) begin
          d = int'($signed(io.out_data));
          @(posedge clk); #1;
          chk({tag, "_stall_stable"}, int'($signed(io.out_data)), d, 0);
          chk({tag, "_stall_valid"}, int'(io.out_valid), 1, 0);
        end else begin
          @(posedge clk); #1;
        end
        wd++;
        io.out_ready = ($urandom_range(99) >= stall);
      end
      if (!to) begin
        got[i] = int'($signed(io.out_data));
        chk({tag, "_last"}, int'(io.out_last), (i == 7) ? 1 : 0, 0);
        @(posedge clk); #1;
      end
    end
    io.out_ready = 1'b0;
    chk({tag, "_ready_after"}, int'(io.in_ready), 1, 0);
    chk({tag, "_valid_after"}, int'(io.out_valid), 0, 0);
  endtask

  initial begin
    int xs[8], got[8], ex[8];
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(io.in_ready), 1, 0);
    chk("rst_out_valid", int'(io.out_valid), 0, 0);
    chk("rst_out_data", int'(io.out_data), 0, 0);
    chk("rst_out_last", int'(io.out_last), 0, 0);
    rst = 1'b0;

    // T1 zeros
    xs = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_row(xs, 0);
    recv_row(got, 0, "t1");
    for (int i = 0; i < 8; i++) chk($sformatf("t1_x%0d", i), got[i], 0, 0);

    // T2 DC, with in_valid asserted during CALC to show it is ignored
    xs = '{1024, 0, 0, 0, 0, 0, 0, 0};
    send_row(xs, 0);
    io.in_valid = 1'b1;
    io.in_data  = 16'h7abc;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t2_in_ready_calc", int'(io.in_ready), 0, 0);
    end
    io.in_valid = 1'b0;
    recv_row(got, 0, "t2");
    for (int i = 0; i < 8; i++) chk($sformatf("t2_x%0d", i), got[i], 362, 1);

    // T3 first odd basis
    xs = '{0, 1000, 0, 0, 0, 0, 0, 0};
    ex = '{490, 416, 278, 98, -98, -278, -416, -490};
    send_row(xs, 0);
    recv_row(got, 0, "t3");
    for (int i = 0; i < 8; i++) chk($sformatf("t3_x%0d", i), got[i], ex[i], 1);

    // T4 even inputs at full scale: x0 = x7 = 44576, x1 = -8867
    xs = '{32767, 0, 32767, 0, 32767, 0, 32767, 0};
    send_row(xs, 0);
    recv_row(got, 0, "t4");
`ifdef IDCT_SAT_EN
    chk("t4_x0", got[0], 32767, 0);
    chk("t4_x7", got[7], 32767, 0);
`else
    chk("t4_x0", got[0], 44576 - 65536, 0);
    chk("t4_x7", got[7], 44576 - 65536, 0);
`endif
    chk("t4_x1", got[1], -8867, 0);
    chk("t4_x3", got[3], 1763, 0);

    // T6 reset mid-CALC, then a clean row
    xs = '{0, 1000, 0, 0, 0, 0, 0, 0};
    send_row(xs, 0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_in_ready", int'(io.in_ready), 1, 0);
    chk("t6_out_valid", int'(io.out_valid), 0, 0);
    xs = '{1024, 0, 0, 0, 0, 0, 0, 0};
    send_row(xs, 0);
    recv_row(got, 0, "t6");
    for (int i = 0; i < 8; i++) chk($sformatf("t6_x%0d", i), got[i], 362, 1);

    // T5 random rows with input gaps and output back-pressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) xs[k] = $urandom_range(4000) - 2000;
      send_row(xs, 30);
      recv_row(got, 40, "t5");
      for (int i = 0; i < 8; i++) chk($sformatf("t5_r%0d_x%0d", r, i), got[i], model(xs, i), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
